// File: rtl/uart_link_arbiter.sv
// uart_link_arbiter
//   Shares one UART link (UartTx/UartRx pair) to the analog MCU between four
//   requesters. A transaction is one command byte sent over UartTx, followed
//   by 0..2 response bytes received over UartRx. Requesters are served
//   round-robin, one transaction at a time. Each response byte has its own
//   timeout, so a silent MCU cannot hold the link forever.
//
// Ports
//   clock_i        system clock
//   reset_i        asynchronous, active-high reset
//   reqValid_i     per-requester request; held with cmd/len until own respValid
//   reqCmd_i       command byte per requester, [8i+7:8i] = requester i
//   reqLen_i       response byte count per requester, [2i+1:2i]; 3 acts as 2
//   grant_o        one-hot owner of the link
//   busy_o         transaction in progress
//   respValid_o    one-cycle pulse to the owner at transaction end
//   respData_o     first rx byte in [7:0], second in [15:8]; missing bytes are 0
//   respTimeout_o  qualifies respValid_o: transaction ended by timeout
//   txReq_o        UartTx send request, held until txDone_i
//   txData_o       UartTx byte, stable while txReq_o is high
//   txDone_i       UartTx send complete
//   rxReady_o      UartRx ready-for-rx level
//   rxData_i       UartRx received byte
//   rxComplete_i   UartRx byte complete; stays high until rxReady_o drops
module uart_link_arbiter #(
    parameter int TIMEOUT_TICKS = 24000
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic [3:0]  reqValid_i,
    input  logic [31:0] reqCmd_i,
    input  logic [7:0]  reqLen_i,
    output logic [3:0]  grant_o,
    output logic        busy_o,
    output logic [3:0]  respValid_o,
    output logic [15:0] respData_o,
    output logic        respTimeout_o,
    output logic        txReq_o,
    output logic [7:0]  txData_o,
    input  logic        txDone_i,
    output logic        rxReady_o,
    input  logic [7:0]  rxData_i,
    input  logic        rxComplete_i
);

    localparam int TW = (TIMEOUT_TICKS > 2) ? $clog2(TIMEOUT_TICKS) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_TICKS - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SEND = 3'd1,
        RECV = 3'd2,
        GAP  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     ptr_q, ptr_d;
    logic [3:0]     grant_q, grant_d;
    logic           busy_q, busy_d;
    logic           tx_req_q, tx_req_d;
    logic [7:0]     tx_data_q, tx_data_d;
    logic           rx_ready_q, rx_ready_d;
    logic [1:0]     len_q, len_d;
    logic [1:0]     idx_q, idx_d;
    logic [15:0]    resp_data_q, resp_data_d;
    logic           tmo_q, tmo_d;
    logic [TW-1:0]  timer_q, timer_d;

    // Per-requester views of the packed command/length buses.
    logic [7:0] cmd_arr [4];
    logic [1:0] len_arr [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_unpack
        assign cmd_arr[gi] = reqCmd_i[8*gi +: 8];
        assign len_arr[gi] = reqLen_i[2*gi +: 2];
    end

    // Round-robin pick: first active request at or after ptr_q, wrapping.
    // The 2-bit index addition wraps modulo 4 on its own.
    logic [1:0] arb_winner;
    logic       arb_found;

    always_comb begin
        arb_found  = 1'b0;
        arb_winner = ptr_q;
        for (int k = 0; k < 4; k++) begin
            if (!arb_found && reqValid_i[ptr_q + 2'(k)]) begin
                arb_found  = 1'b1;
                arb_winner = ptr_q + 2'(k);
            end
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            ptr_q       <= 2'd0;
            grant_q     <= 4'd0;
            busy_q      <= 1'b0;
            tx_req_q    <= 1'b0;
            tx_data_q   <= 8'd0;
            rx_ready_q  <= 1'b0;
            len_q       <= 2'd0;
            idx_q       <= 2'd0;
            resp_data_q <= 16'd0;
            tmo_q       <= 1'b0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
            tx_req_q    <= tx_req_d;
            tx_data_q   <= tx_data_d;
            rx_ready_q  <= rx_ready_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            resp_data_q <= resp_data_d;
            tmo_q       <= tmo_d;
            timer_q     <= timer_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        busy_d      = busy_q;
        tx_req_d    = tx_req_q;
        tx_data_d   = tx_data_q;
        rx_ready_d  = rx_ready_q;
        len_d       = len_q;
        idx_d       = idx_q;
        resp_data_d = resp_data_q;
        tmo_d       = tmo_q;
        timer_d     = timer_q;

        unique case (state_q)
            IDLE: begin
                if (arb_found) begin
                    ptr_d       = arb_winner + 2'd1;
                    grant_d     = 4'b0001 << arb_winner;
                    busy_d      = 1'b1;
                    tx_data_d   = cmd_arr[arb_winner];
                    tx_req_d    = 1'b1;
                    // A length code of 3 is clamped to the 2-byte maximum.
                    len_d       = (len_arr[arb_winner] == 2'd3) ? 2'd2 : len_arr[arb_winner];
                    idx_d       = 2'd0;
                    resp_data_d = 16'd0;
                    tmo_d       = 1'b0;
                    state_d     = SEND;
                end
            end

            SEND: begin
                if (txDone_i) begin
                    tx_req_d = 1'b0;
                    if (len_q == 2'd0) begin
                        state_d = DONE;
                    end else begin
                        rx_ready_d = 1'b1;
                        timer_d    = '0;
                        state_d    = RECV;
                    end
                end
            end

            RECV: begin
                timer_d = timer_q + TW'(1);
                // A byte arriving in the expiry cycle wins over the timeout.
                if (rxComplete_i) begin
                    if (idx_q == 2'd0) begin
                        resp_data_d[7:0] = rxData_i;
                    end else begin
                        resp_data_d[15:8] = rxData_i;
                    end
                    idx_d      = idx_q + 2'd1;
                    rx_ready_d = 1'b0;
                    state_d    = GAP;
                end else if (timer_q == TIMER_LAST) begin
                    rx_ready_d = 1'b0;
                    tmo_d      = 1'b1;
                    state_d    = GAP;
                end
            end

            GAP: begin
                // UartRx keeps complete high until it sees rxReady low, so
                // wait for it to rearm before asking for another byte.
                if (!rxComplete_i) begin
                    if (tmo_q || (idx_q == len_q)) begin
                        state_d = DONE;
                    end else begin
                        rx_ready_d = 1'b1;
                        timer_d    = '0;
                        state_d    = RECV;
                    end
                end
            end

            DONE: begin
                grant_d = 4'd0;
                busy_d  = 1'b0;
                tmo_d   = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The response pulse is decoded from the DONE state so it lasts exactly
    // one cycle and vanishes immediately on reset.
    assign respValid_o   = (state_q == DONE) ? grant_q : 4'd0;
    assign respTimeout_o = (state_q == DONE) && tmo_q;
    assign respData_o    = resp_data_q;
    assign grant_o       = grant_q;
    assign busy_o        = busy_q;
    assign txReq_o       = tx_req_q;
    assign txData_o      = tx_data_q;
    assign rxReady_o     = rx_ready_q;

endmodule
